// File: rtl/shared_timer_arbiter.sv
// Round-robin owner of one shared interval counter; grant registered one cycle after req, done pulses limit cycles after grant.
// Define SHARED_TIMER_B2B_EN to arbitrate inside DONE and remove the idle gap between consecutive grants.
module shared_timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] interval,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         count_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW    = IDX_W + 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        ptr;
  logic [NUM_CNT_BITS-1:0] limit;

  logic [NUM_REQ-1:0]      idx_oh;
  logic [IDX_W-1:0]        arb_base;
  logic [NUM_REQ-1:0]      arb_cand;
  logic                    sel_vld;
  logic [IDX_W-1:0]        sel_idx;
  logic [PW-1:0]           pos;
  logic [NUM_CNT_BITS-1:0] sel_ivl;
  logic [NUM_CNT_BITS-1:0] sel_limit;
  logic [NUM_REQ-1:0]      sel_oh;

  assign idx_oh = NUM_REQ'(1) << idx;

  // In DONE the search starts after the finishing owner and skips it.
  assign arb_base = (state == DONE) ? idx : ptr;
  assign arb_cand = (state == DONE) ? (req & ~idx_oh) : req;

  // Walk from farthest to nearest so the nearest set bit after arb_base wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    pos     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = {1'b0, arb_base} + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (arb_cand[pos[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = pos[IDX_W-1:0];
      end
    end
  end

  assign sel_ivl   = interval[sel_idx*NUM_CNT_BITS +: NUM_CNT_BITS];
  assign sel_limit = (sel_ivl == '0) ? NUM_CNT_BITS'(1) : sel_ivl;
  assign sel_oh    = NUM_REQ'(1) << sel_idx;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      idx       <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      limit     <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      count_out <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          count_out <= '0;
          if (sel_vld) begin
            state <= COUNT;
            idx   <= sel_idx;
            limit <= sel_limit;
            grant <= sel_oh;
            busy  <= 1'b1;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        COUNT: begin
          // An owner dropping req forfeits the interval and its priority.
          if (!req[idx]) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            count_out <= '0;
            ptr       <= idx;
          end else if (count_out + 1'b1 == limit) begin
            state     <= DONE;
            count_out <= limit;
            done      <= idx_oh;
          end else begin
            count_out <= count_out + 1'b1;
          end
        end
        DONE: begin
          ptr       <= idx;
          count_out <= '0;
`ifdef SHARED_TIMER_B2B_EN
          if (sel_vld) begin
            state <= COUNT;
            idx   <= sel_idx;
            limit <= sel_limit;
            grant <= sel_oh;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          busy      <= 1'b0;
          count_out <= '0;
        end
      endcase
    end
  end
endmodule
